// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: architectural register names, register
// file depth and the write-address select (RegDst) encodings.
package mips_pkg;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_RA    = 5'd31;
  localparam int         GRF_DEPTH = 32;

  // Write-address select encodings, shared with the RegDst mux stage.
  typedef enum logic [1:0] {
    RT = 2'd0,
    RD = 2'd1,
    RA = 2'd2
  } regdst_e;

  // True when an address refers to the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [4:0] a);
    return (a == REG_ZERO);
  endfunction

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port of the general register file.
// Resolves $0 -> zero, optional same-cycle write bypass, else stored value.
module grf_read_port
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 1
) (
  input  logic [DEPTH_LOG2-1:0]                     ra,
  input  logic [DEPTH_LOG2-1:0]                     wa,
  input  logic                                      byp_en,
  input  logic [WIDTH-1:0]                          wd,
  input  logic [(2**DEPTH_LOG2)-1:0][WIDTH-1:0]     regs,
  output logic [WIDTH-1:0]                          rd
);

  // Read resolution: zero register first, then bypass, then storage.
  always_comb begin
    rd = '0;
    if (ra != '0) begin
      if ((BYPASS != 0) && byp_en && (ra == wa)) begin
        rd = wd;
      end else begin
        rd = regs[ra];
      end
    end
  end

endmodule

// File: rtl/grf_writeback.sv
// General register file for the single-cycle MIPS datapath.
// 2**DEPTH_LOG2 registers of WIDTH bits, $0 hardwired to zero, two
// combinational read ports and a count of committed writes.
// Optional build macro GRF_TRACE_EN prints one line per committed write.
module grf_writeback
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic [DEPTH_LOG2-1:0] ra1,
  input  logic [DEPTH_LOG2-1:0] ra2,
  input  logic [DEPTH_LOG2-1:0] wa,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wd,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        commit;
  logic                        byp_en;

  // A write commits only out of reset and never to $0.
  assign commit = we && (wa != '0);

  // Bypass is suppressed while reset is held so both ports read zero.
  assign byp_en = we && reset;

  // Register storage and write counter; entry 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs     <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[wa] <= wd;
      wr_count <= wr_count + 32'd1;
    end
  end

  grf_read_port #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BYPASS     (BYPASS)
  ) u_port1 (
    .ra     (ra1),
    .wa     (wa),
    .byp_en (byp_en),
    .wd     (wd),
    .regs   (regs),
    .rd     (rd1)
  );

  grf_read_port #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BYPASS     (BYPASS)
  ) u_port2 (
    .ra     (ra2),
    .wa     (wa),
    .byp_en (byp_en),
    .wd     (wd),
    .regs   (regs),
    .rd     (rd2)
  );

`ifdef GRF_TRACE_EN
  // Simulation trace of every committed write; no effect on state.
  always_ff @(posedge clk) begin
    if (reset && commit) begin
      $display("@%08h: $%02d <= %08h", pc, wa, wd);
    end
  end
`else
  // pc only feeds the trace; fold it into a deliberately unused net.
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf_writeback.sv
// Scoreboard bench for grf_writeback: directed scenarios followed by
// randomized traffic checked against a simple array model of the register file.
module tb_grf_writeback;

  localparam int BYP = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [4:0]  ra1, ra2, wa;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, wr_count;

  grf_writeback #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(BYP)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .ra1      (ra1),
    .ra2      (ra2),
    .wa       (wa),
    .we       (we),
    .wd       (wd),
    .rd1      (rd1),
    .rd2      (rd2),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  logic [31:0] mcnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural read rule applied to the model state.
  function automatic logic [31:0] model_read(input logic r, input logic [4:0] a,
                                             input logic w, input logic [4:0] waddr,
                                             input logic [31:0] wdata);
    if (!r || a == 5'd0) return 32'd0;
    if (BYP != 0 && w && a == waddr) return wdata;
    return model[a];
  endfunction

  // One clock cycle of stimulus: drive just after the rising edge, record the
  // expected read-out for this cycle, then apply the write the next edge commits.
  task automatic cyc(input logic r, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [4:0] x1,
                     input logic [4:0] x2, input logic [31:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; we = w; wa = a; wd = d; ra1 = x1; ra2 = x2; pc = p;
    if (!r) begin
      foreach (model[i]) model[i] = 32'd0;
      mcnt = 32'd0;
    end
    e.rd1 = model_read(r, x1, w, a, d);
    e.rd2 = model_read(r, x2, w, a, d);
    e.cnt = mcnt;
    sb.push_back(e);
    if (r && w && a != 5'd0) begin
      model[a] = d;
      mcnt = mcnt + 32'd1;
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd1", rd1, e.rd1);
        check("rd2", rd2, e.rd2);
        check("wr_count", wr_count, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    foreach (model[i]) model[i] = 32'd0;
    mcnt = 32'd0;
    reset = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0; ra1 = 5'd0; ra2 = 5'd0; pc = 32'd0;

    // Power-on reset, then release.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 32'd0);

    // Populate $5 and $31, then pulse reset mid-cycle and read them.
    cyc(1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0, 32'd0);
    cyc(1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 5'd5, 5'd31, 32'd0);
    cyc(1'b0, 1'b0, 5'd0,  32'd0, 5'd5, 5'd31, 32'd0);
    #1;
    check("reset_rd1_imm", rd1, 32'd0);
    check("reset_rd2_imm", rd2, 32'd0);
    check("reset_cnt_imm", wr_count, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 32'd0);

    // Basic write/read.
    cyc(1'b1, 1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 32'd0);
    #1;
    check("basic_rd1", rd1, 32'h12345678);
    check("basic_cnt", wr_count, 32'd1);

    // $0 write is discarded.
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0);
    #1;
    check("zero_rd1", rd1, 32'd0);
    check("zero_cnt", wr_count, 32'd1);

    // Same-cycle bypass on both ports, then stored value after the edge.
    cyc(1'b1, 1'b1, 5'd9, 32'hA, 5'd0, 5'd0, 32'd0);
    cyc(1'b1, 1'b1, 5'd9, 32'hB, 5'd9, 5'd9, 32'd0);
    #1;
    check("bypass_rd1", rd1, 32'hB);
    check("bypass_rd2", rd2, 32'hB);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 32'd0);

    // jal link into $31.
    cyc(1'b1, 1'b1, 5'd31, 32'h00003008, 5'd0, 5'd0, 32'h00003004);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd31, 32'h00003008);
    #1;
    check("jal_rd2", rd2, 32'h00003008);

    // Reset asserted in the same cycle as a write: reset wins.
    cyc(1'b1, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 32'd0);
    cyc(1'b0, 1'b1, 5'd4, 32'h77, 5'd3, 5'd4, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 32'd0);
    #1;
    check("rstwr_rd1", rd1, 32'd0);
    check("rstwr_rd2", rd2, 32'd0);
    check("rstwr_cnt", wr_count, 32'd0);

    // Randomized traffic: concentrated addresses so reads often hit writes.
    for (int i = 0; i < 3000; i++) begin
      logic        r, w;
      logic [4:0]  a, x1, x2;
      r  = ($urandom_range(0, 99) != 0);
      w  = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      x1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 7));
      x2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      cyc(r, w, a, $urandom, x1, x2, $urandom);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
